seven_seg_scanner: RTL and testbench

- Parametrised N-digit multiplexed seven-segment driver for the vending-machine front panel.
- Replaces the fixed 4-digit display path. Adds per-digit blanking, decimal points, PWM brightness, anti-ghosting guard time, frame-coherent input capture and leading-zero suppression.
- Sits between the price/credit BCD logic and the board's common-anode display pins.

---
 rtl/seven_seg_pkg.sv | 53 +++++
 rtl/seven_seg_scanner_seg_decode.sv | 11 +
 rtl/seven_seg_scanner.sv | 163 ++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: segment patterns,
// hex decode and index sizing. Segment bits are {g,f,e,d,c,b,a}, active-low.
package seven_seg_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

  // Digit index width, $clog2(num_digits), never narrower than one bit.
  function automatic int idx_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_seg_decode.sv
// Combinational nibble-to-segment lookup for the currently scanned digit.
module seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_scanner.sv
// N-digit multiplexed common-anode seven-segment driver with guard time, PWM
// brightness, frame-coherent capture and leading-zero suppression.
// Optional per-digit blinking is built when SEVSEG_BLINK_EN is defined.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 2,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_en,
  input  logic [BRIGHT_W-1:0]     brightness,
`ifdef SEVSEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink,
`endif
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              ca,
  output logic                    dp
);

  localparam int IDX_W  = idx_width(NUM_DIGITS);
  localparam int SLOT_W = $clog2(REFRESH_DIV);

  if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS ||
      REFRESH_DIV <= GUARD_CYCLES + 1 || BLINK_FRAMES < 1) begin : g_param_err
    $error("seven_seg_scanner: illegal parameter combination");
  end

  logic [SLOT_W-1:0]       slot_cnt;
  logic [IDX_W-1:0]        idx;
  logic [BRIGHT_W-1:0]     pwm_cnt;
  logic                    started;

  logic [4*NUM_DIGITS-1:0] digits_sh;
  logic [NUM_DIGITS-1:0]   dp_sh;
  logic [NUM_DIGITS-1:0]   blank_sh;
  logic                    lz_sh;
  logic [BRIGHT_W-1:0]     bright_sh;

  logic slot_last, idx_last, frame_wrap, frame_start;
  logic in_guard, pwm_ok, blink_dark, dark_digit, lit;
  logic upper_zero;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [3:0]              sel_nib;
  logic [6:0]              seg;

  assign slot_last   = (slot_cnt == SLOT_W'(REFRESH_DIV - 1));
  assign idx_last    = (idx == IDX_W'(NUM_DIGITS - 1));
  assign frame_wrap  = slot_last && idx_last;
  // Load the snapshot on the first clock out of reset and whenever idx returns to 0.
  assign frame_start = !started || frame_wrap;

  if (GUARD_CYCLES == 0) begin : g_no_guard
    assign in_guard = 1'b0;
  end else begin : g_guard
    assign in_guard = (slot_cnt < SLOT_W'(GUARD_CYCLES));
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      slot_cnt <= '0;
      idx      <= '0;
      pwm_cnt  <= '0;
      started  <= 1'b0;
    end else begin
      started <= 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (slot_last) begin
        slot_cnt <= '0;
        idx      <= idx_last ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      digits_sh <= '0;
      dp_sh     <= '0;
      blank_sh  <= '0;
      lz_sh     <= 1'b0;
      bright_sh <= '0;
    end else if (frame_start) begin
      digits_sh <= digits;
      dp_sh     <= dp_in;
      blank_sh  <= blank;
      lz_sh     <= lz_en;
      bright_sh <= brightness;
    end
  end

`ifdef SEVSEG_BLINK_EN
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FRAME_W-1:0]    frame_cnt;
  logic                  blink_phase;
  logic [NUM_DIGITS-1:0] blink_sh;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      blink_sh    <= '0;
    end else begin
      if (frame_start) blink_sh <= blink;
      if (frame_wrap) begin
        if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  assign blink_dark = blink_phase && blink_sh[idx];
`else
  assign blink_dark = 1'b0;
`endif

  // A digit above 0 is a leading zero when it and every digit above it are 0.
  always_comb begin
    suppress   = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero  = upper_zero && (digits_sh[4*i +: 4] == 4'h0);
      suppress[i] = lz_sh && upper_zero;
    end
  end

  assign sel_nib    = digits_sh[{idx, 2'b00} +: 4];
  assign pwm_ok     = (bright_sh == '1) || (pwm_cnt < bright_sh);
  assign dark_digit = blank_sh[idx] || suppress[idx] || blink_dark;
  assign lit        = !in_guard && pwm_ok && !dark_digit;

  seg_decode u_seg_decode (
    .nibble (sel_nib),
    .seg    (seg)
  );

  // ca/dp follow the scanned digit even in guard so the pattern settles before the anode turns on.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      an <= '1;
      ca <= SEG_OFF;
      dp <= 1'b1;
    end else begin
      an <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      ca <= seg;
      dp <= dark_digit ? 1'b1 : ~dp_sh[idx];
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner (4 digits, 8-clock slots, 2-clock guard,
// 2-bit brightness). The blink scenario is built when SEVSEG_BLINK_EN is defined.
module tb_seven_seg_scanner;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic [15:0]   digits = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    blank = '0;
  logic          lz_en = 1'b0;
  logic [1:0]    brightness = '0;
`ifdef SEVSEG_BLINK_EN
  logic [3:0]    blink = '0;
`endif
  logic [3:0]    an;
  logic [6:0]    ca;
  logic          dp;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seven_seg_scanner #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (8),
    .GUARD_CYCLES (2),
    .BRIGHT_W     (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank      (blank),
    .lz_en      (lz_en),
    .brightness (brightness),
`ifdef SEVSEG_BLINK_EN
    .blink      (blink),
`endif
    .an         (an),
    .ca         (ca),
    .dp         (dp)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset while loading inputs, releases between edges, then takes the
  // first edge (snapshot load). Afterwards the output seen after edge k shows
  // slot (k-1)%8 of digit ((k-1)/8)%4 with pwm count (k-1)%4.
  task automatic start(input logic [15:0] d, input logic [3:0] dpv,
                       input logic [3:0] bl, input logic lz, input logic [1:0] br);
    clr        = 1'b0;
    digits     = d;
    dp_in      = dpv;
    blank      = bl;
    lz_en      = lz;
    brightness = br;
    tick();
    tick();
    clr = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if ({an, ca, dp} !== {4'hF, 7'h7F, 1'b1}) begin
        miscompares++;
        $display("FAIL reset c=%0d got an=%b ca=%h dp=%b want an=1111 ca=7f dp=1", c, an, ca, dp);
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] ea;
    logic [6:0] ec;
    int s, i;
    start(16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd3);
    for (int k = 2; k <= 64; k++) begin
      tick();
      s  = (k - 1) % 8;
      i  = ((k - 1) / 8) % 4;
      ea = (s >= 2) ? ~(4'b0001 << i) : 4'hF;
      ec = SEG_TBL[digits[4*i +: 4]];
      vectors++;
      if ({an, ca, dp} !== {ea, ec, 1'b1}) begin
        miscompares++;
        $display("FAIL scan k=%0d got an=%b ca=%h dp=%b want an=%b ca=%h dp=1", k, an, ca, dp, ea, ec);
      end
    end
  endtask

  task automatic test_pwm();
    logic [3:0] ea;
    int s, i, p, lit_cnt;
    start(16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd1);
    lit_cnt = 0;
    for (int k = 2; k <= 33; k++) begin
      tick();
      s  = (k - 1) % 8;
      i  = ((k - 1) / 8) % 4;
      p  = (k - 1) % 4;
      ea = (s >= 2 && p == 0) ? ~(4'b0001 << i) : 4'hF;
      if (an != 4'hF) lit_cnt++;
      vectors++;
      if (an !== ea) begin
        miscompares++;
        $display("FAIL pwm1 k=%0d got an=%b want an=%b", k, an, ea);
      end
    end
    // one lit clock (slot count 4) per 8-clock slot over four slots
    vectors++;
    if (lit_cnt != 4) begin
      miscompares++;
      $display("FAIL pwm1_count got %0d lit cycles want 4", lit_cnt);
    end
    start(16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd0);
    for (int k = 2; k <= 33; k++) begin
      tick();
      vectors++;
      if (an !== 4'hF) begin
        miscompares++;
        $display("FAIL pwm0 k=%0d got an=%b want an=1111", k, an);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] ea;
    logic [6:0] ec;
    int s, i;
    start(16'h0050, 4'b0000, 4'b0000, 1'b1, 2'd3);
    for (int k = 2; k <= 33; k++) begin
      tick();
      s  = (k - 1) % 8;
      i  = ((k - 1) / 8) % 4;
      ea = (s >= 2 && i < 2) ? ~(4'b0001 << i) : 4'hF;
      ec = (i == 1) ? 7'h12 : 7'h40;
      vectors++;
      if ({an, ca, dp} !== {ea, ec, 1'b1}) begin
        miscompares++;
        $display("FAIL lz0050 k=%0d got an=%b ca=%h dp=%b want an=%b ca=%h dp=1", k, an, ca, dp, ea, ec);
      end
    end
    start(16'h0000, 4'b0000, 4'b0000, 1'b1, 2'd3);
    for (int k = 2; k <= 33; k++) begin
      tick();
      s  = (k - 1) % 8;
      i  = ((k - 1) / 8) % 4;
      ea = (s >= 2 && i == 0) ? 4'b1110 : 4'hF;
      vectors++;
      if ({an, ca} !== {ea, 7'h40}) begin
        miscompares++;
        $display("FAIL lz0000 k=%0d got an=%b ca=%h want an=%b ca=40", k, an, ca, ea);
      end
    end
  endtask

  task automatic test_frame_coherence();
    logic [3:0] ea;
    logic [6:0] ec;
    int s, i;
    start(16'h1111, 4'b0000, 4'b0000, 1'b0, 2'd3);
    for (int k = 2; k <= 48; k++) begin
      tick();
      if (k == 20) digits = 16'h2222;
      s  = (k - 1) % 8;
      i  = ((k - 1) / 8) % 4;
      ea = (s >= 2) ? ~(4'b0001 << i) : 4'hF;
      ec = (k <= 32) ? 7'h79 : 7'h24;
      vectors++;
      if ({an, ca} !== {ea, ec}) begin
        miscompares++;
        $display("FAIL coherence k=%0d got an=%b ca=%h want an=%b ca=%h", k, an, ca, ea, ec);
      end
    end
  endtask

  task automatic test_blank_dp();
    logic [3:0] ea;
    logic       ed;
    int s, i;
    // dp also requested on digit 2, which is blanked and must keep dp dark
    start(16'h1234, 4'b0101, 4'b0100, 1'b0, 2'd3);
    for (int k = 2; k <= 40; k++) begin
      tick();
      s  = (k - 1) % 8;
      i  = ((k - 1) / 8) % 4;
      ea = (s >= 2 && i != 2) ? ~(4'b0001 << i) : 4'hF;
      ed = (i == 0) ? 1'b0 : 1'b1;
      vectors++;
      if ({an, dp} !== {ea, ed}) begin
        miscompares++;
        $display("FAIL blank_dp k=%0d got an=%b dp=%b want an=%b dp=%b", k, an, dp, ea, ed);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] ea;
    logic [6:0] ec;
    int s, i;
    start(16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd3);
    for (int k = 2; k <= 20; k++) tick();
    vectors++;
    if ({an, ca} !== {4'b1011, 7'h24}) begin
      miscompares++;
      $display("FAIL midrst_pre got an=%b ca=%h want an=1011 ca=24", an, ca);
    end
    clr = 1'b0;
    #1;
    vectors++;
    if ({an, ca, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      miscompares++;
      $display("FAIL midrst_async got an=%b ca=%h dp=%b want an=1111 ca=7f dp=1", an, ca, dp);
    end
    tick();
    clr = 1'b1;
    tick();
    for (int k = 2; k <= 24; k++) begin
      tick();
      s  = (k - 1) % 8;
      i  = ((k - 1) / 8) % 4;
      ea = (s >= 2) ? ~(4'b0001 << i) : 4'hF;
      ec = SEG_TBL[digits[4*i +: 4]];
      vectors++;
      if ({an, ca} !== {ea, ec}) begin
        miscompares++;
        $display("FAIL midrst_restart k=%0d got an=%b ca=%h want an=%b ca=%h", k, an, ca, ea, ec);
      end
    end
  endtask

`ifdef SEVSEG_BLINK_EN
  task automatic test_blink();
    logic [3:0] ea;
    logic       dark0;
    int s, i, f;
    blink = 4'b0001;
    start(16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd3);
    for (int k = 2; k <= 160; k++) begin
      tick();
      s     = (k - 1) % 8;
      i     = ((k - 1) / 8) % 4;
      f     = (k - 1) / 32;
      dark0 = (i == 0) && (f == 2 || f == 3);
      ea    = (s >= 2 && !dark0) ? ~(4'b0001 << i) : 4'hF;
      vectors++;
      if (an !== ea) begin
        miscompares++;
        $display("FAIL blink k=%0d frame=%0d got an=%b want an=%b", k, f, an, ea);
      end
    end
    blink = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_pwm();
    test_leading_zero();
    test_frame_coherence();
    test_blank_dp();
    test_mid_reset();
`ifdef SEVSEG_BLINK_EN
    test_blink();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
